multi_debounce: RTL and testbench
=================================

Name: multi_debounce

Overview:
- Parametrised successor to the single-channel delay/debounce block: debounces CHANNELS independent asynchronous inputs in both directions, rising and falling.
- Each channel has its own input synchronizer, glitch-rejecting FSM and stable-cycle counter.
- Each channel drives a clean level, one-cycle rise/fall pulses and a busy flag.
- Sits between raw pushbutton/switch pins and the control FSMs.

Parameters:
CHANNELS, 4, number of independent input channels (≥1)
STABLE_CYCLES, 4, consecutive synchronized samples of the new value required to change the output level (≥2)
SYNC_STAGES, 2, synchronizer flop depth per channel (≥2)
CNT_W, $clog2(STABLE_CYCLES), derived localparam, counter width; not overridable

Ports:
clk  input  1  system clock, all logic on posedge
clear  input  1  reset, asynchronous, active-high; all state cleared immediately on assertion
en  input  1  FSM advance enable; 0 freezes FSMs, counters and outputs; synchronizers keep running
din  input  CHANNELS  raw asynchronous inputs
level  output  CHANNELS  debounced level
rise  output  CHANNELS  one-cycle pulse when level goes 0→1
fall  output  CHANNELS  one-cycle pulse when level goes 1→0
busy  output  CHANNELS  channel is in a WAIT state (candidate change pending)

Behaviour:
- Reset (clear=1, async):
  - sync flops=0, state=LOW, cnt=0.
  - level=0, rise=0, fall=0, busy=0.
- Synchronizer:
  - SYNC_STAGES-flop chain per channel.
  - s[i] is the last stage output; the FSM samples only s[i].
- Per-channel FSM (s = s[i]); all transitions only when en=1:
  - LOW: s=1 → RISE_WAIT, cnt=1. Otherwise stay.
  - RISE_WAIT:
    - s=0 → LOW, cnt=0 (glitch rejected, no pulse).
    - s=1 and cnt==STABLE_CYCLES-1 → HIGH, level<=1, rise<=1, cnt=0.
    - Otherwise cnt+1.
  - HIGH: s=0 → FALL_WAIT, cnt=1. Otherwise stay.
  - FALL_WAIT:
    - s=1 → HIGH, cnt=0 (glitch rejected).
    - s=0 and cnt==STABLE_CYCLES-1 → LOW, level<=0, fall<=1, cnt=0.
    - Otherwise cnt+1.
- busy=1 exactly while state ∈ {RISE_WAIT, FALL_WAIT}. Registered, updated on the same edge as the state.
- Pulses:
  - rise/fall are registered and high for exactly one cycle.
  - Default 0 every cycle, including cycles with en=0.
  - rise and fall never both 1 on the same channel.
- Latency: a clean din edge changes level on the (SYNC_STAGES+STABLE_CYCLES)-th posedge after the edge. That is 6 cycles with defaults.
- Glitch rule: any pulse on s shorter than STABLE_CYCLES samples produces no level change and no pulse. busy rises then falls.
- en=0 mid-wait: state and cnt hold. Counting resumes from the held value when en returns to 1.
- Counter: CNT_W bits, never exceeds STABLE_CYCLES-1, no wrap.
- Channels are fully independent. Simultaneous events on different channels are each handled in the same cycle.
- clear mid-operation: immediate return to reset values.
  - An in-flight pulse is dropped; no fall pulse is generated for a level that was high.
  - If din is held high through reset, level re-rises with a rise pulse SYNC_STAGES+STABLE_CYCLES cycles after clear deasserts.

Decomposition:
- Package multi_debounce_pkg:
  - state typedef (LOW=2'b00, RISE_WAIT=2'b01, HIGH=2'b10, FALL_WAIT=2'b11).
  - Default parameter constants.
- Sub-module debounce_cell: one channel, containing synchronizer, FSM, counter, level/rise/fall/busy.
- Top instantiates CHANNELS cells with a generate loop and shares clk/clear/en.

Test Plan:
1. Reset, din=4'b0000, en=1 for 20 cycles → level=0, rise/fall/busy never asserted.
2. din[0] 0→1 held high → busy[0]=1 from cycle 3; level[0]=1 and rise[0]=1 for exactly one cycle at cycle 6. Other channels stay 0.
3. din[1] high for 3 cycles then low → busy[1] pulses; level[1], rise[1] and fall[1] stay 0.
4. din[2] high, settled, then low held → fall[2] single pulse 6 cycles after the falling edge; level[2]=0. During FALL_WAIT, a 2-cycle high glitch restores HIGH with no pulses.
5. din[3] rises, en=0 after 4 cycles for 5 cycles, then en=1 → rise[3] delayed by exactly 5 cycles versus scenario 2. No pulse while en=0.
6. level=4'b1111, assert clear for 1 cycle mid-run with din held high → all outputs 0 immediately. All rise bits pulse together 6 cycles after clear deasserts; no fall pulses.

Source files
------------

// File: rtl/multi_debounce_pkg.sv
// Shared types and default parameters for the multi-channel debouncer.
package multi_debounce_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'b00,
    RISE_WAIT = 2'b01,
    HIGH      = 2'b10,
    FALL_WAIT = 2'b11
  } db_state_e;

  localparam int unsigned DEF_CHANNELS      = 4;
  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/debounce_cell.sv
// One debounce channel: input synchronizer, glitch-rejecting FSM, stable counter,
// registered level / rise / fall / busy outputs.
module debounce_cell
  import multi_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic clear,
  input  logic en,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_d, rise_d, fall_d, busy_d;

  // Synchronizer runs regardless of en so the FSM sees fresh data on resume.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
      rise    <= rise_d;
      fall    <= fall_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en) begin
      case (state_q)
        LOW: begin
          if (s) begin
            state_d = RISE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        RISE_WAIT: begin
          if (!s) begin
            state_d = LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HIGH;
            level_d = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HIGH: begin
          if (!s) begin
            state_d = FALL_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        FALL_WAIT: begin
          if (s) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = LOW;
            level_d = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
    end
    busy_d = (state_d == RISE_WAIT) || (state_d == FALL_WAIT);
  end

endmodule

// File: rtl/multi_debounce.sv
// CHANNELS independent debounce cells sharing clock, clear and enable.
module multi_debounce
  import multi_debounce_pkg::*;
#(
  parameter int unsigned CHANNELS      = DEF_CHANNELS,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                en,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] busy
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_cell #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES),
      .CNT_W        (CNT_W)
    ) u_cell (
      .clk  (clk),
      .clear(clear),
      .en   (en),
      .din  (din[i]),
      .level(level[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .busy (busy[i])
    );
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Directed testbench for multi_debounce with default parameters (4 ch, 4 stable, 2 sync).
module tb_multi_debounce;

  logic       clk;
  logic       clear;
  logic       en;
  logic [3:0] din;
  logic [3:0] level, rise, fall, busy;

  int checks   = 0;
  int failures = 0;

  multi_debounce #(
    .CHANNELS     (4),
    .STABLE_CYCLES(4),
    .SYNC_STAGES  (2)
  ) dut (
    .clk  (clk),
    .clear(clear),
    .en   (en),
    .din  (din),
    .level(level),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
    $fatal(1);
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    clear = 1'b1; en = 1'b1; din = 4'b0000;
    step(); step();
    exp = '0;
    checks++;
    if ({level, rise, fall, busy} !== exp) begin
      failures++;
      $display("FAIL reset_held: got %h expected %h", {level, rise, fall, busy}, exp);
    end
    clear = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if ({level, rise, fall, busy} !== exp) begin
        failures++;
        $display("FAIL idle cycle %0d: got %h expected %h", k, {level, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_rise_fall_ch0();
    logic [15:0] exp;
    din[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = {3'b000, 1'(k >= 6), 3'b000, 1'(k == 6), 4'b0000, 3'b000, 1'(k >= 3 && k <= 5)};
      checks++;
      if ({level, rise, fall, busy} !== exp) begin
        failures++;
        $display("FAIL ch0_rise cycle %0d: got %h expected %h", k, {level, rise, fall, busy}, exp);
      end
    end
    din[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = {3'b000, 1'(k < 6), 4'b0000, 3'b000, 1'(k == 6), 3'b000, 1'(k >= 3 && k <= 5)};
      checks++;
      if ({level, rise, fall, busy} !== exp) begin
        failures++;
        $display("FAIL ch0_fall cycle %0d: got %h expected %h", k, {level, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_glitch_ch1();
    logic [15:0] exp;
    din[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) din[1] = 1'b0;
      step();
      exp = {12'h000, 2'b00, 1'(k >= 3 && k <= 5), 1'b0};
      checks++;
      if ({level, rise, fall, busy} !== exp) begin
        failures++;
        $display("FAIL ch1_glitch cycle %0d: got %h expected %h", k, {level, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_fall_glitch_ch2();
    logic [15:0] exp;
    din[2] = 1'b1;
    repeat (8) step();
    checks++;
    if (level !== 4'b0100) begin
      failures++;
      $display("FAIL ch2_settled_high: got %b expected %b", level, 4'b0100);
    end
    din[2] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = {1'b0, 1'(k < 6), 2'b00, 4'b0000, 1'b0, 1'(k == 6), 2'b00, 1'b0, 1'(k >= 3 && k <= 5), 2'b00};
      checks++;
      if ({level, rise, fall, busy} !== exp) begin
        failures++;
        $display("FAIL ch2_fall cycle %0d: got %h expected %h", k, {level, rise, fall, busy}, exp);
      end
    end
    din[2] = 1'b1;
    repeat (8) step();
    din[2] = 1'b0;
    repeat (3) step();
    checks++;
    if (busy !== 4'b0100) begin
      failures++;
      $display("FAIL ch2_in_fall_wait: got %b expected %b", busy, 4'b0100);
    end
    // Two-cycle high glitch on din while waiting to fall, then held low.
    for (int g = 1; g <= 12; g++) begin
      din[2] = (g <= 2);
      step();
      exp = {1'b0, 1'(g < 8), 2'b00, 4'b0000, 1'b0, 1'(g == 8), 2'b00,
             1'b0, 1'(g <= 2 || (g >= 5 && g <= 7)), 2'b00};
      checks++;
      if ({level, rise, fall, busy} !== exp) begin
        failures++;
        $display("FAIL ch2_glitch cycle %0d: got %h expected %h", g, {level, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_enable_ch3();
    logic [15:0] exp;
    din[3] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      en = !(k >= 5 && k <= 9);
      step();
      exp = {1'(k >= 11), 3'b000, 1'(k == 11), 3'b000, 4'b0000, 1'(k >= 3 && k <= 10), 3'b000};
      checks++;
      if ({level, rise, fall, busy} !== exp) begin
        failures++;
        $display("FAIL ch3_enable cycle %0d: got %h expected %h", k, {level, rise, fall, busy}, exp);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_clear_midrun();
    logic [15:0] exp;
    din = 4'b1111;
    repeat (8) step();
    checks++;
    if (level !== 4'b1111) begin
      failures++;
      $display("FAIL all_high_before_clear: got %b expected %b", level, 4'b1111);
    end
    clear = 1'b1;
    #1;
    checks++;
    if ({level, rise, fall, busy} !== 16'h0000) begin
      failures++;
      $display("FAIL clear_immediate: got %h expected %h", {level, rise, fall, busy}, 16'h0000);
    end
    step();
    clear = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = {(k >= 6) ? 4'hF : 4'h0, (k == 6) ? 4'hF : 4'h0, 4'h0,
             (k >= 3 && k <= 5) ? 4'hF : 4'h0};
      checks++;
      if ({level, rise, fall, busy} !== exp) begin
        failures++;
        $display("FAIL clear_rerise cycle %0d: got %h expected %h", k, {level, rise, fall, busy}, exp);
      end
    end
  endtask

  initial begin
    clear = 1'b1;
    en    = 1'b1;
    din   = 4'b0000;
    test_reset();
    test_rise_fall_ch0();
    test_glitch_ch1();
    test_fall_glitch_ch2();
    test_enable_ch3();
    test_clear_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
